msg_field_parser: RTL and testbench

- Inverse of the PoW message builder: accepts the 123-byte mining message as a byte stream and extracts its fields into registered wide outputs.
- Validates the header bytes, the message length and the equality of the two rdata copies.
- Sits on the host/UART ingress side, ahead of job registers, so host-supplied or loop-back messages can be checked against the locally built message.

---
 rtl/msg_field_parser_pkg.sv | 58 +++++
 rtl/msg_field_parser_if.sv | 37 +++
 rtl/msg_field_parser_byte_router.sv | 58 +++++
 rtl/msg_field_parser.sv | 184 ++++++++++++++++++
 tb/tb_msg_field_parser.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_field_parser_pkg.sv
// -----------------------------------------------------------------------------
// msg_field_parser_pkg
// Shared definitions for the 123-byte mining message parser:
//   - byte offsets and lengths of every field in the message
//   - error code enum reported on o_err
//   - parser state enum
//   - field-select enum produced by the byte router
// -----------------------------------------------------------------------------
package msg_field_parser_pkg;

  // Field offsets (byte index of the first byte of each field)
  localparam logic [6:0] OFS_OP     = 7'd2;
  localparam logic [6:0] OFS_FLAGS  = 7'd6;
  localparam logic [6:0] OFS_EXPIRE = 7'd7;
  localparam logic [6:0] OFS_MYADDR = 7'd11;
  localparam logic [6:0] OFS_RDATA  = 7'd43;
  localparam logic [6:0] OFS_PSEED  = 7'd75;
  localparam logic [6:0] OFS_RDATA2 = 7'd91;
  localparam logic [6:0] MSG_LEN    = 7'd123;

  // Field lengths in bytes
  localparam logic [6:0] LEN_OP     = 7'd4;
  localparam logic [6:0] LEN_FLAGS  = 7'd1;
  localparam logic [6:0] LEN_EXPIRE = 7'd4;
  localparam logic [6:0] LEN_MYADDR = 7'd32;
  localparam logic [6:0] LEN_RDATA  = 7'd32;
  localparam logic [6:0] LEN_PSEED  = 7'd16;

  // Index of the final byte of a well-formed message
  localparam logic [6:0] LAST_IDX = MSG_LEN - 7'd1;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HDR   = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_RDATA = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    FLD_D1     = 4'd0,
    FLD_D2     = 4'd1,
    FLD_OP     = 4'd2,
    FLD_FLAGS  = 4'd3,
    FLD_EXPIRE = 4'd4,
    FLD_MYADDR = 4'd5,
    FLD_RDATA  = 4'd6,
    FLD_PSEED  = 4'd7,
    FLD_RDATA2 = 4'd8,
    FLD_NONE   = 4'd9
  } field_e;

endpackage

// File: rtl/msg_field_parser_if.sv
// -----------------------------------------------------------------------------
// msg_field_parser_if
// Byte-stream ingress and parse-result egress of msg_field_parser.
//   i_valid/i_data/i_last/o_ready : byte stream into the parser
//   o_valid/i_ready               : result handshake out of the parser
//   o_err, o_op, o_flags, o_expire, o_myaddr, o_rdata, o_pseed : result
// Modports:
//   master : byte source / result consumer (host side)
//   slave  : the parser
// -----------------------------------------------------------------------------
interface msg_field_parser_if;
  logic         i_valid;
  logic [7:0]   i_data;
  logic         i_last;
  logic         o_ready;
  logic         o_valid;
  logic         i_ready;
  logic [1:0]   o_err;
  logic [31:0]  o_op;
  logic [7:0]   o_flags;
  logic [31:0]  o_expire;
  logic [255:0] o_myaddr;
  logic [255:0] o_rdata;
  logic [127:0] o_pseed;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_err, o_op, o_flags, o_expire,
           o_myaddr, o_rdata, o_pseed
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_err, o_op, o_flags, o_expire,
           o_myaddr, o_rdata, o_pseed
  );
endinterface

// File: rtl/msg_field_parser_byte_router.sv
// -----------------------------------------------------------------------------
// msg_byte_router
// Combinational decode of a message byte index into the field it belongs to
// and the byte lane inside that field.
//   cnt   in  7 : byte index within the message
//   field out   : field select (FLD_NONE beyond the last message byte)
//   lane  out 5 : byte lane counted from the field LSB, so the first byte of a
//                 field maps to its most significant lane
// -----------------------------------------------------------------------------
module msg_byte_router
  import msg_field_parser_pkg::*;
(
  input  logic [6:0] cnt,
  output field_e     field,
  output logic [4:0] lane
);

  localparam logic [6:0] END_OP     = OFS_OP     + LEN_OP     - 7'd1;
  localparam logic [6:0] END_FLAGS  = OFS_FLAGS  + LEN_FLAGS  - 7'd1;
  localparam logic [6:0] END_EXPIRE = OFS_EXPIRE + LEN_EXPIRE - 7'd1;
  localparam logic [6:0] END_MYADDR = OFS_MYADDR + LEN_MYADDR - 7'd1;
  localparam logic [6:0] END_RDATA  = OFS_RDATA  + LEN_RDATA  - 7'd1;
  localparam logic [6:0] END_PSEED  = OFS_PSEED  + LEN_PSEED  - 7'd1;
  localparam logic [6:0] END_RDATA2 = OFS_RDATA2 + LEN_RDATA  - 7'd1;

  // Lane = (last byte of field) - cnt. Every field is at most 32 bytes, so
  // the subtraction is exact when done modulo 32 on the low five bits.
  always_comb begin
    field = FLD_NONE;
    lane  = 5'd0;
    if (cnt == 7'd0) begin
      field = FLD_D1;
    end else if (cnt == 7'd1) begin
      field = FLD_D2;
    end else if (cnt <= END_OP) begin
      field = FLD_OP;
      lane  = END_OP[4:0] - cnt[4:0];
    end else if (cnt <= END_FLAGS) begin
      field = FLD_FLAGS;
    end else if (cnt <= END_EXPIRE) begin
      field = FLD_EXPIRE;
      lane  = END_EXPIRE[4:0] - cnt[4:0];
    end else if (cnt <= END_MYADDR) begin
      field = FLD_MYADDR;
      lane  = END_MYADDR[4:0] - cnt[4:0];
    end else if (cnt <= END_RDATA) begin
      field = FLD_RDATA;
      lane  = END_RDATA[4:0] - cnt[4:0];
    end else if (cnt <= END_PSEED) begin
      field = FLD_PSEED;
      lane  = END_PSEED[4:0] - cnt[4:0];
    end else if (cnt <= END_RDATA2) begin
      field = FLD_RDATA2;
      lane  = END_RDATA2[4:0] - cnt[4:0];
    end
  end

endmodule

// File: rtl/msg_field_parser.sv
// -----------------------------------------------------------------------------
// msg_field_parser
// Parses the 123-byte mining message from a byte stream into registered wide
// field outputs, checking the two header bytes, the message length and that
// both rdata copies agree.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : msg_field_parser_if.slave (byte stream in, parse result out)
// Parameters:
//   D1_EXP, D2_EXP : required values of bytes 0 and 1
//   FLAGS_EXP      : required flags byte (byte 6)
// Build option:
//   PARSER_FLAGS_CHECK_EN : when defined, a flags byte other than FLAGS_EXP
//                           is reported as a header error.
// -----------------------------------------------------------------------------
module msg_field_parser
  import msg_field_parser_pkg::*;
#(
  parameter logic [7:0] D1_EXP    = 8'h00,
  parameter logic [7:0] D2_EXP    = 8'hF2,
  parameter logic [7:0] FLAGS_EXP = 8'hFC
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  msg_field_parser_if.slave  bus
);

`ifdef PARSER_FLAGS_CHECK_EN
  localparam bit FLAGS_CHK = 1'b1;
`else
  localparam bit FLAGS_CHK = 1'b0;
`endif

  state_e       state_reg, state_next;
  logic [6:0]   cnt_reg, cnt_next;
  logic         hdr_err_reg, hdr_err_next;
  logic         len_err_reg, len_err_next;
  logic         rd_err_reg, rd_err_next;

  logic [31:0]  op_reg;
  logic [7:0]   flags_reg;
  logic [31:0]  expire_reg;
  logic [255:0] myaddr_reg;
  logic [255:0] rdata_reg;
  logic [127:0] pseed_reg;

  field_e       fld;
  logic [4:0]   lane;
  logic         ready;
  logic         accept;
  logic         route_en;
  logic         hdr_hit;
  logic         rd_hit;
  err_e         err;

  msg_byte_router u_router (
    .cnt   (cnt_reg),
    .field (fld),
    .lane  (lane)
  );

  assign ready    = (state_reg != DONE);
  assign accept   = bus.i_valid && ready;
  assign route_en = accept && (state_reg == RECV);

  // Per-byte checks against the header constants and the stored first rdata copy
  always_comb begin
    hdr_hit = 1'b0;
    rd_hit  = 1'b0;
    case (fld)
      FLD_D1:     hdr_hit = (bus.i_data != D1_EXP);
      FLD_D2:     hdr_hit = (bus.i_data != D2_EXP);
      FLD_FLAGS:  hdr_hit = FLAGS_CHK && (bus.i_data != FLAGS_EXP);
      FLD_RDATA2: rd_hit  = (rdata_reg[{lane, 3'b000} +: 8] != bus.i_data);
      default:    ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= RECV;
      cnt_reg     <= 7'd0;
      hdr_err_reg <= 1'b0;
      len_err_reg <= 1'b0;
      rd_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hdr_err_reg <= hdr_err_next;
      len_err_reg <= len_err_next;
      rd_err_reg  <= rd_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hdr_err_next = hdr_err_reg;
    len_err_next = len_err_reg;
    rd_err_next  = rd_err_reg;
    case (state_reg)
      RECV: begin
        if (accept) begin
          cnt_next     = cnt_reg + 7'd1;
          hdr_err_next = hdr_err_reg | hdr_hit;
          rd_err_next  = rd_err_reg | rd_hit;
          if (cnt_reg == LAST_IDX) begin
            if (bus.i_last) begin
              state_next = DONE;
            end else begin
              // Overlong message: flag it and swallow the tail
              len_err_next = 1'b1;
              state_next   = DRAIN;
            end
          end else if (bus.i_last) begin
            len_err_next = 1'b1;
            state_next   = DONE;
          end
        end
      end
      DRAIN: begin
        if (accept && bus.i_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_next   = RECV;
          cnt_next     = 7'd0;
          hdr_err_next = 1'b0;
          len_err_next = 1'b0;
          rd_err_next  = 1'b0;
        end
      end
      default: state_next = RECV;
    endcase
  end

  // Field capture; registers keep their contents across messages
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_reg     <= '0;
      flags_reg  <= '0;
      expire_reg <= '0;
      myaddr_reg <= '0;
      rdata_reg  <= '0;
      pseed_reg  <= '0;
    end else if (route_en) begin
      case (fld)
        FLD_OP:     op_reg[{lane[1:0], 3'b000} +: 8]     <= bus.i_data;
        FLD_FLAGS:  flags_reg                            <= bus.i_data;
        FLD_EXPIRE: expire_reg[{lane[1:0], 3'b000} +: 8] <= bus.i_data;
        FLD_MYADDR: myaddr_reg[{lane, 3'b000} +: 8]      <= bus.i_data;
        FLD_RDATA:  rdata_reg[{lane, 3'b000} +: 8]       <= bus.i_data;
        FLD_PSEED:  pseed_reg[{lane[3:0], 3'b000} +: 8]  <= bus.i_data;
        default:    ;
      endcase
    end
  end

  // Length beats header beats rdata
  always_comb begin
    err = ERR_NONE;
    if (len_err_reg) begin
      err = ERR_LEN;
    end else if (hdr_err_reg) begin
      err = ERR_HDR;
    end else if (rd_err_reg) begin
      err = ERR_RDATA;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = (state_reg == DONE);
  assign bus.o_err    = err;
  assign bus.o_op     = op_reg;
  assign bus.o_flags  = flags_reg;
  assign bus.o_expire = expire_reg;
  assign bus.o_myaddr = myaddr_reg;
  assign bus.o_rdata  = rdata_reg;
  assign bus.o_pseed  = pseed_reg;

endmodule

// File: tb/tb_msg_field_parser.sv
// -----------------------------------------------------------------------------
// tb_msg_field_parser
// Directed bench for msg_field_parser. The stimulus process sends messages and
// pushes the expected result into a queue; an independent monitor compares the
// head of the queue with the DUT whenever o_valid is high and pops it when the
// result is accepted.
// -----------------------------------------------------------------------------
module tb_msg_field_parser;
  import msg_field_parser_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  msg_field_parser_if bus ();

  msg_field_parser dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]   err;
    bit           chk;
    logic [31:0]  op;
    logic [7:0]   flags;
    logic [31:0]  expire;
    logic [255:0] myaddr;
    logic [255:0] rdata;
    logic [127:0] pseed;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks     = 0;
  int n_fail       = 0;
  int pushes       = 0;
  int pops         = 0;
  int cyc          = 0;
  int stall_cnt    = 0;
  int last_acc_cyc = 0;
  bit prev_valid   = 1'b0;

  logic [7:0]   msg [0:129];
  logic [31:0]  op_v;
  logic [31:0]  expire_v;
  logic [255:0] myaddr_v;
  logic [255:0] rdata_v;
  logic [127:0] pseed_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_msg(input logic [7:0] flags_b);
    msg[0] = 8'h00;
    msg[1] = 8'hF2;
    for (int i = 0; i < 4; i++) msg[2 + i] = op_v[31 - 8*i -: 8];
    msg[6] = flags_b;
    for (int i = 0; i < 4; i++) msg[7 + i] = expire_v[31 - 8*i -: 8];
    for (int i = 0; i < 32; i++) msg[11 + i] = myaddr_v[255 - 8*i -: 8];
    for (int i = 0; i < 32; i++) msg[43 + i] = rdata_v[255 - 8*i -: 8];
    for (int i = 0; i < 16; i++) msg[75 + i] = pseed_v[127 - 8*i -: 8];
    for (int i = 0; i < 32; i++) msg[91 + i] = rdata_v[255 - 8*i -: 8];
    for (int i = 123; i < 130; i++) msg[i] = 8'h5A;
  endtask

  // Present one byte and hold it until the parser takes it
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit rdy;
    int guard;
    guard = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = last;
    forever begin
      @(negedge clk);
      rdy = bus.o_ready;
      @(posedge clk);
      if (rdy) break;
      stall_cnt++;
      guard++;
      if (guard > 200) begin
        check("byte_accept_timeout", 1, 0);
        break;
      end
    end
    #1;
    last_acc_cyc = cyc;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_byte(msg[i], (i == n - 1));
  endtask

  task automatic push_exp(input logic [1:0] err, input bit chk, input logic [7:0] flags_e);
    exp_t e;
    e.err     = err;
    e.chk     = chk;
    e.op      = op_v;
    e.flags   = flags_e;
    e.expire  = expire_v;
    e.myaddr  = myaddr_v;
    e.rdata   = rdata_v;
    e.pseed   = pseed_v;
    e.acc_cyc = last_acc_cyc;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.o_ready && exp_q.size() == 0) break;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whenever a result is presented, pop on acceptance
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_valid) begin
        check("ready_low_in_done", bus.o_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = exp_q[0];
          $display("result: err=%0d op=%h flags=%h i_ready=%0d", bus.o_err, bus.o_op, bus.o_flags, bus.i_ready);
          if (!prev_valid) check("valid_latency", cyc, mon_e.acc_cyc);
          check("err", bus.o_err, mon_e.err);
          if (mon_e.chk) begin
            check("op", bus.o_op, mon_e.op);
            check("flags", bus.o_flags, mon_e.flags);
            check("expire", bus.o_expire, mon_e.expire);
            check("myaddr", bus.o_myaddr, mon_e.myaddr);
            check("rdata", bus.o_rdata, mon_e.rdata);
            check("pseed", bus.o_pseed, mon_e.pseed);
          end
          if (bus.i_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      prev_valid = bus.o_valid;
    end
  end

  initial begin
    op_v     = 32'h4D696E65;
    expire_v = 32'hDEADBEEF;
    myaddr_v = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    rdata_v  = 256'h0123456789ABCDEFFEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0;
    pseed_v  = {16{8'hAA}};

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    build_msg(8'hFC);

    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_err", bus.o_err, 0);
    check("rst_op", bus.o_op, 0);
    check("rst_myaddr", bus.o_myaddr, 0);
    check("rst_pseed", bus.o_pseed, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Valid message
    $display("txn: valid message");
    stall_cnt = 0;
    send_msg(123);
    push_exp(ERR_NONE, 1'b1, 8'hFC);
    check("valid_no_stall", stall_cnt, 0);

    // Second rdata copy differs at byte 100
    $display("txn: rdata copy mismatch at byte 100");
    build_msg(8'hFC);
    msg[100] = msg[100] ^ 8'hFF;
    wait_idle();
    send_msg(123);
    push_exp(ERR_RDATA, 1'b1, 8'hFC);

    // Bad header plus early i_last: length wins
    $display("txn: bad d2 and i_last on byte 50");
    build_msg(8'hFC);
    msg[1] = 8'hF0;
    wait_idle();
    send_msg(51);
    push_exp(ERR_LEN, 1'b0, 8'hFC);

    // Overlong 130-byte stream
    $display("txn: 130-byte stream through DRAIN");
    build_msg(8'hFC);
    wait_idle();
    stall_cnt = 0;
    send_msg(130);
    push_exp(ERR_LEN, 1'b0, 8'hFC);
    check("drain_no_stall", stall_cnt, 0);

    // Single-byte message
    $display("txn: single-byte message");
    wait_idle();
    send_msg(1);
    push_exp(ERR_LEN, 1'b0, 8'hFC);

    // Consumer holds off for 10 cycles while the next message is offered
    $display("txn: backpressure hold then next message");
    build_msg(8'hFC);
    wait_idle();
    bus.i_ready = 1'b0;
    send_msg(123);
    push_exp(ERR_NONE, 1'b1, 8'hFC);
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
      begin
        send_msg(123);
        push_exp(ERR_NONE, 1'b1, 8'hFC);
      end
    join

    // Reset in the middle of a message carrying a header error
    $display("txn: reset at byte 60 then valid message");
    build_msg(8'hFC);
    msg[1] = 8'hF0;
    wait_idle();
    for (int i = 0; i < 60; i++) send_byte(msg[i], 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_msg(8'hFC);
    send_msg(123);
    push_exp(ERR_NONE, 1'b1, 8'hFC);

    // Flags byte 0x00
    $display("txn: flags byte 0x00");
    build_msg(8'h00);
    wait_idle();
    send_msg(123);
`ifdef PARSER_FLAGS_CHECK_EN
    push_exp(ERR_HDR, 1'b0, 8'h00);
`else
    push_exp(ERR_NONE, 1'b1, 8'h00);
`endif

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(posedge clk);
    check("all_results_seen", pops, pushes);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
